fp_mul_ieee: RTL and testbench
==============================

# fp_mul_ieee

Parametrised, fully pipelined IEEE-754 floating-point multiplier. It is the next-generation multiplier for the FPU datapath. It accepts one operand pair per cycle and returns a result a fixed 4 cycles later, with round-to-nearest-even rounding. It handles zero, infinity and NaN operands, and flushes subnormals to zero. It drives real overflow, underflow and exception flags, plus sticky versions of them, for the FPU status register.

## Interface
Parameters:
- DATA_W, 32: total format width (sign + exponent + fraction).
- EXP_W, 8: exponent width. Fraction width F = DATA_W-EXP_W-1. Bias = 2^(EXP_W-1)-1.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- start, input, 1: operand pair valid this cycle.
- op_a, op_b, input, DATA_W each: operands, sampled when start=1.
- clr_flags, input, 1: synchronous clear of the sticky flags.
- done, output, 1: res and the flags are valid this cycle.
- res, output, DATA_W: product.
- overflow, underflow, exception, output, 1 each: per-result flags, valid with done.
- sticky_flags, output, 3: accumulated flags, {exception, underflow, overflow}.

## Operation
- Pipeline, with no backpressure. A new start is accepted every cycle.
  - S1: unpack and classify operands.
  - S2: F+1 by F+1 mantissa multiply; exponent sum.
  - S3: normalise; derive guard, round and sticky bits.
  - S4: round, resolve special cases, pack, and register the outputs.
- Valid bit: start propagates through 4 valid flops. done is the S4 valid flop.
- Classification of each operand:
  - zero: exponent 0, any fraction. Subnormals are treated as zero (FTZ on input).
  - inf: exponent all ones, fraction 0.
  - NaN: exponent all ones, fraction non-zero.
- Sign: sign_a XOR sign_b. This applies to every non-NaN result, including zero and inf.
- Exponent datapath: signed, EXP_W+2 bits, E = Ea + Eb - Bias.
  - Add 1 if the product MSB is set; the mantissa is then shifted right 1 and the dropped bit is ORed into sticky.
  - Add a further 1 if rounding carries out of the mantissa; the mantissa becomes 1.0.
- Rounding is RNE. Round up when G & (R | S | lsb). S is the OR of every product bit below R.
- Result priority (first match wins):
  1. Either operand is NaN, or zero x inf: res = canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0); exception=1.
  2. Either operand is inf: res = ±inf.
  3. Either operand is zero: res = ±0.
  4. Final E >= 2^EXP_W-1: res = ±inf; overflow=1.
  5. Final E <= 0: res = ±0; underflow=1 (FTZ on output).
  6. Otherwise: normal packed result.
- Flag scope: flags are only set by cases 1, 4 and 5. At most one flag is high per result.
- sticky_flags:
  - Each bit ORs in the matching per-result flag whenever done=1.
  - clr_flags=1 zeroes all bits. If clr_flags and a flagged done occur in the same cycle, the clear wins and the new flag is lost.

## Timing
- Latency: start in cycle N gives done=1 in cycle N+4. Throughput is 1 per cycle. The order of results equals the order of starts.
- done is high for exactly one cycle per start. Back-to-back starts give back-to-back done.
- res and the per-result flags update only on cycles where done=1 and hold their value otherwise.
- Reset values:
  - done=0, res=0, overflow=0, underflow=0, exception=0, sticky_flags=0.
  - All pipeline registers and valid bits are cleared.
- Reset asserted mid-operation: every in-flight operation is discarded, and no done appears for it after reset is released.
- start=0 with arbitrary operands has no effect on any output.

## Test plan
- Basic multiply: 0x3FC00000 x 0x40000000, start in cycle 0 -> done in cycle 4, res=0x40400000, all flags 0.
- RNE tie: 0x3F800001 x 0x3FC00000 -> res=0x3FC00002 (tie rounded to even). Also 0x3F800001 x 0x3F800001 -> res=0x3F800002.
- Overflow and underflow:
  - 0x7F7FFFFF x 0x40000000 -> res=0x7F800000, overflow=1.
  - 0x00800000 x 0x00800000 -> res=0x00000000, underflow=1.
  - Then sticky_flags=3'b011. Pulse clr_flags -> sticky_flags=0.
- Special operands:
  - 0x80000000 x 0x7F800000 -> res=0x7FC00000, exception=1.
  - 0xFF800000 x 0x40000000 -> res=0xFF800000, no flags.
  - 0x00000001 (subnormal) x 0x40000000 -> res=0x00000000.
- Streaming: 8 consecutive starts with distinct operands -> 8 consecutive done pulses, results in order, each checked against a reference model.
- Reset mid-stream: 3 starts, then rst_n low in cycle 2 -> no done after release, all outputs 0. A new start after release produces a correct result 4 cycles later.

Source files
------------

// File: rtl/fp_mul_ieee.sv
// Four-stage pipelined IEEE-754 multiplier: round-to-nearest-even, flush-to-zero on
// input and output, canonical qNaN, per-result and sticky status flags.
module fp_mul_ieee #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              clr_flags,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic              overflow,
  output logic              underflow,
  output logic              exception,
  output logic [2:0]        sticky_flags
);

  localparam int F  = DATA_W - EXP_W - 1;
  localparam int M  = F + 1;
  localparam int P  = 2 * M;
  localparam int EW = EXP_W + 2;
  localparam int FR = F + 1;
  localparam logic [EW-1:0]     BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0]     EXP_INF = EW'((1 << EXP_W) - 1);
  localparam logic [DATA_W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(F-1){1'b0}}};

  // Operand classes are merged in S1; S4 applies them in priority order nan > inf > zero.
  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic sign;
  } cls_t;

  typedef struct packed {
    cls_t             cls;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [M-1:0]     mant_a;
    logic [M-1:0]     mant_b;
  } s1_t;

  typedef struct packed {
    cls_t          cls;
    logic [EW-1:0] exp;
    logic [P-1:0]  prod;
  } s2_t;

  typedef struct packed {
    cls_t          cls;
    logic [EW-1:0] exp;
    logic [F-1:0]  frac;
    logic          g;
    logic          r;
    logic          s;
  } s3_t;

  logic [3:0]        vld_d, vld_q;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;
  s3_t               s3_d, s3_q;
  logic [DATA_W-1:0] res_d, res_q;
  logic              ovf_d, ovf_q;
  logic              unf_d, unf_q;
  logic              exc_d, exc_q;
  logic [2:0]        sticky_d, sticky_q;

  assign vld_d = {vld_q[2:0], start};

  // S1: unpack and classify; subnormals count as zero
  always_comb begin : s1_comb
    logic [EXP_W-1:0] ea, eb;
    logic [F-1:0]     fa, fb;
    logic             za, zb, ia, ib, na, nb;
    ea = op_a[DATA_W-2 -: EXP_W];
    eb = op_b[DATA_W-2 -: EXP_W];
    fa = op_a[F-1:0];
    fb = op_b[F-1:0];
    za = (ea == '0);
    zb = (eb == '0);
    ia = (&ea) && (fa == '0);
    ib = (&eb) && (fb == '0);
    na = (&ea) && (fa != '0);
    nb = (&eb) && (fb != '0);
    s1_d.cls.nan  = na | nb | ((za | zb) & (ia | ib));
    s1_d.cls.inf  = ia | ib;
    s1_d.cls.zero = za | zb;
    s1_d.cls.sign = op_a[DATA_W-1] ^ op_b[DATA_W-1];
    s1_d.exp_a    = ea;
    s1_d.exp_b    = eb;
    s1_d.mant_a   = {~za, fa};
    s1_d.mant_b   = {~zb, fb};
  end

  // S2: full-width mantissa product and biased exponent sum
  always_comb begin : s2_comb
    s2_d.cls  = s1_q.cls;
    s2_d.exp  = EW'(s1_q.exp_a) + EW'(s1_q.exp_b) - BIAS;
    s2_d.prod = P'(s1_q.mant_a) * P'(s1_q.mant_b);
  end

  // S3: product lies in [1,4); a set MSB means one extra right shift into sticky
  always_comb begin : s3_comb
    s3_d.cls = s2_q.cls;
    if (s2_q.prod[P-1]) begin
      s3_d.exp  = s2_q.exp + EW'(1);
      s3_d.frac = s2_q.prod[P-2 -: F];
      s3_d.g    = s2_q.prod[F];
      s3_d.r    = s2_q.prod[F-1];
      s3_d.s    = |s2_q.prod[F-2:0];
    end else begin
      s3_d.exp  = s2_q.exp;
      s3_d.frac = s2_q.prod[P-3 -: F];
      s3_d.g    = s2_q.prod[F-1];
      s3_d.r    = s2_q.prod[F-2];
      s3_d.s    = |s2_q.prod[F-3:0];
    end
  end

  // S4: round, resolve specials, pack; outputs only move when a result lands
  always_comb begin : s4_comb
    logic          rnd;
    logic [F:0]    frac_r;
    logic [EW-1:0] exp_f;
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
    res_d = res_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    exc_d = exc_q;
    rnd    = s3_q.g & (s3_q.r | s3_q.s | s3_q.frac[0]);
    // Hidden bit is always 1 here, so a carry out of the fraction means mantissa 10.0 -> 1.0.
    frac_r = {1'b0, s3_q.frac} + FR'(rnd);
    exp_f  = s3_q.exp + EW'(frac_r[F]);
    if (vld_q[2]) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
      exc_d = 1'b0;
      if (s3_q.cls.nan) begin
        res_d = QNAN;
        exc_d = 1'b1;
      end else if (s3_q.cls.inf) begin
        res_d = {s3_q.cls.sign, {EXP_W{1'b1}}, {F{1'b0}}};
      end else if (s3_q.cls.zero) begin
        res_d = {s3_q.cls.sign, {(DATA_W-1){1'b0}}};
      end else if ($signed(exp_f) >= $signed(EXP_INF)) begin
        res_d = {s3_q.cls.sign, {EXP_W{1'b1}}, {F{1'b0}}};
        ovf_d = 1'b1;
      end else if (exp_f[EW-1] || exp_f == '0) begin
        res_d = {s3_q.cls.sign, {(DATA_W-1){1'b0}}};
        unf_d = 1'b1;
      end else begin
        res_d = {s3_q.cls.sign, exp_f[EXP_W-1:0], frac_r[F-1:0]};
      end
    end
  end

  // A clear in the same cycle as a flagged result wins
  always_comb begin : sticky_comb
    sticky_d = sticky_q | ({3{vld_q[3]}} & {exc_q, unf_q, ovf_q});
    if (clr_flags) sticky_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: pipeline data registers are reset along with the valid bits so no stale operand survives a mid-stream reset.
    if (!rst_n) begin
      vld_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      exc_q    <= 1'b0;
      sticky_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage read its predecessor's old value, which is what makes this a pipeline.
      vld_q    <= vld_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      exc_q    <= exc_d;
      sticky_q <= sticky_d;
    end
  end

  assign done         = vld_q[3];
  assign res          = res_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign exception    = exc_q;
  assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fp_mul_ieee.sv
// Scoreboard bench for fp_mul_ieee: a driver pushes expected results, a negedge
// monitor pops and compares on done, and checks hold, reset and sticky behaviour.
module tb_fp_mul_ieee;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        clr_flags = 1'b0;
  logic        done;
  logic [31:0] res;
  logic        overflow, underflow, exception;
  logic [2:0]  sticky_flags;

  fp_mul_ieee #(.DATA_W(32), .EXP_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op_a         (op_a),
    .op_b         (op_b),
    .clr_flags    (clr_flags),
    .done         (done),
    .res          (res),
    .overflow     (overflow),
    .underflow    (underflow),
    .exception    (exception),
    .sticky_flags (sticky_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;   // {exception, underflow, overflow}
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] last_res = '0;
  logic [2:0]  last_flags = '0;
  logic [2:0]  exp_sticky = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: exact integer product, rounded by comparing the discarded remainder to one half ulp.
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, e, sh;
    longint fa, fb, p, q, rem, half;
    logic   s, za, zb, ia, ib, na, nb;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    if (na || nb || ((za || zb) && (ia || ib))) return {3'b100, 32'h7FC0_0000};
    if (ia || ib) return {3'b000, s, 8'hFF, 23'h0};
    if (za || zb) return {3'b000, s, 31'h0};
    p = ((longint'(1) << 23) + fa) * ((longint'(1) << 23) + fb);
    e = ea + eb - 127;
    if (p >= (longint'(1) << 47)) begin
      sh = 24;
      e++;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {3'b001, s, 8'hFF, 23'h0};
    if (e <= 0) return {3'b010, s, 31'h0};
    return {3'b000, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    f = 23'($urandom);
    case ($urandom_range(0, 9))
      0: e = 8'h00;
      1: begin
        e = 8'hFF;
        if ($urandom_range(0, 1) == 1) f = '0;
      end
      2: e = 8'($urandom_range(1, 12));
      3: e = 8'($urandom_range(240, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    if ($urandom_range(0, 7) == 0) f = '1;
    return {1'($urandom), e, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      op_a  = $urandom;
      op_b  = $urandom;
      tick();
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [2:0] fl);
    exp_t e;
    e.res   = r;
    e.flags = fl;
    e.cyc   = cyc;
    sb_q.push_back(e);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic issue_rand();
    logic [31:0] a, b;
    logic [34:0] m;
    a = rand_op();
    b = rand_op();
    m = ref_mul(a, b);
    issue(a, b, m[31:0], m[34:32]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: sampled at negedge, away from the active edge.
  exp_t       mon_e;
  logic [2:0] mon_nxt;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", {done, res, overflow, underflow, exception, sticky_flags}, '0);
      sb_q.delete();
      last_res   = '0;
      last_flags = '0;
      exp_sticky = '0;
    end else begin
      check("sticky_flags", 64'(sticky_flags), 64'(exp_sticky));
      mon_nxt = '0;
      if (done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 64'(done), 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("res", 64'(res), 64'(mon_e.res));
          check("flags", 64'({exception, underflow, overflow}), 64'(mon_e.flags));
          check("latency", 64'(cyc - mon_e.cyc), 64'd4);
          last_res   = mon_e.res;
          last_flags = mon_e.flags;
          mon_nxt    = mon_e.flags;
        end
      end else begin
        check("hold_res", 64'(res), 64'(last_res));
        check("hold_flags", 64'({exception, underflow, overflow}), 64'(last_flags));
      end
      exp_sticky = clr_flags ? 3'b000 : (exp_sticky | mon_nxt);
    end
  end

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Basic multiply and latency
    issue(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000);
    idle(5);

    // Round-to-nearest-even ties and near-ties
    issue(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 3'b000);
    issue(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b000);

    // Overflow then underflow, then sticky and its clear
    issue(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 3'b001);
    issue(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b010);
    idle(6);
    check("sticky_ovf_unf", 64'(sticky_flags), 64'(3'b011));
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("sticky_cleared", 64'(sticky_flags), 64'(3'b000));

    // Special operands
    issue(32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000, 3'b100);
    issue(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000);
    issue(32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 3'b000);
    idle(6);
    check("sticky_exception", 64'(sticky_flags), 64'(3'b100));

    // Clear coinciding with a flagged done: the clear wins and the flag is lost
    issue(32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b100);
    idle(3);
    clr_flags = 1'b1;
    check("collide_done", 64'(done), 64'd1);
    tick();
    clr_flags = 1'b0;
    idle(2);
    check("sticky_clear_wins", 64'(sticky_flags), 64'(3'b000));

    // Streaming: 8 back-to-back operations
    for (int i = 0; i < 8; i++) issue_rand();
    drain();

    // Random traffic with gaps and occasional clears
    for (int i = 0; i < 300; i++) begin
      clr_flags = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) issue_rand();
      else idle(1);
    end
    clr_flags = 1'b0;
    drain();

    // Reset mid-stream: in-flight work is dropped
    issue_rand();
    issue_rand();
    start = 1'b1;
    op_a  = rand_op();
    op_b  = rand_op();
    rst_n = 1'b0;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(8);
    check("post_reset_outputs", {done, res, overflow, underflow, exception, sticky_flags}, '0);
    issue(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000);
    drain();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
